count_cmd_seq: RTL and testbench

//  Command sequencer directly upstream of the 4-bit mode counter. Queues
//  {mode, data, length} commands, drives the counter's enable/modo/D for

---
 rtl/count_cmd_seq.sv | 145 ++++++++++++++
 tb/tb_count_cmd_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : count_cmd_seq
// Description : Command sequencer feeding a 4-bit mode counter; queues
//               {mode, data, length} commands and reports per-command wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module count_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [3:0]       cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cnt_enable,
    output logic [1:0]       cnt_modo,
    output logic [3:0]       cnt_D,
    input  logic             cnt_rco,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] wraps
);

    localparam int             c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE  = (c_AW+1)'(1);
    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] c_LEN_MAX = {LEN_W{1'b1}};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_TAIL = 2'd2;

    logic [1:0]       r_fifo_mode [DEPTH];
    logic [3:0]       r_fifo_data [DEPTH];
    logic [LEN_W-1:0] r_fifo_len  [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_wrap_cnt;
    logic             r_en_d;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_wrap_inc;
    logic [LEN_W-1:0] w_wrap_next;
    logic [1:0]       w_head_mode;
    logic [3:0]       w_head_data;
    logic [LEN_W-1:0] w_head_len;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & ~w_full;
    assign busy      = (r_state != c_S_IDLE) || ~w_empty;

    assign w_head_mode = r_fifo_mode[r_rd_ptr[c_AW-1:0]];
    assign w_head_data = r_fifo_data[r_rd_ptr[c_AW-1:0]];
    assign w_head_len  = r_fifo_len[r_rd_ptr[c_AW-1:0]];

    // rco is only trusted one cycle after an enabled counter edge.
    assign w_wrap_inc  = r_en_d & cnt_rco;
    assign w_wrap_next = (w_wrap_inc && (r_wrap_cnt != c_LEN_MAX)) ?
                         (r_wrap_cnt + c_LEN_ONE) : r_wrap_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mode[r_wr_ptr[c_AW-1:0]] <= cmd_mode;
            r_fifo_data[r_wr_ptr[c_AW-1:0]] <= cmd_data;
            r_fifo_len[r_wr_ptr[c_AW-1:0]]  <= cmd_len;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = c_S_RUN;
                end
            end
            c_S_RUN: begin
                if (r_rem == c_LEN_ONE) begin
                    w_state_next = c_S_TAIL;
                end
            end
            c_S_TAIL: w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rem      <= '0;
            r_wrap_cnt <= '0;
            r_en_d     <= 1'b0;
            cnt_enable <= 1'b0;
            cnt_modo   <= 2'b00;
            cnt_D      <= 4'h0;
            done       <= 1'b0;
            wraps      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_en_d     <= cnt_enable;
            cnt_enable <= (w_state_next == c_S_RUN);
            done       <= 1'b0;
            r_wrap_cnt <= w_wrap_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                cnt_modo   <= w_head_mode;
                cnt_D      <= w_head_data;
                r_rem      <= (w_head_len == '0) ? c_LEN_ONE : w_head_len;
                r_wrap_cnt <= '0;
            end
            if (r_state == c_S_RUN) begin
                r_rem <= r_rem - c_LEN_ONE;
            end
            // TAIL has just sampled the last rco, so publish the updated count.
            if (r_state == c_S_TAIL) begin
                done  <= 1'b1;
                wraps <= w_wrap_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_cmd_seq
// Description : Directed bench for count_cmd_seq with a 4-bit counter model
//               and a wraps scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_cmd_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'b00;
    logic [3:0] cmd_data = 4'h0;
    logic [7:0] cmd_len = 8'd0;
    logic       cnt_enable;
    logic [1:0] cnt_modo;
    logic [3:0] cnt_D;
    logic       cnt_rco = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] wraps;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_cycles = 0;
    int n_done   = 0;

    logic [7:0] sb[$];
    logic [3:0] q_hist[$];
    logic [3:0] q_pred = 4'h0;
    logic [3:0] ctr_q  = 4'h0;

    always #5 clk = ~clk;

    count_cmd_seq #(.DEPTH(4), .LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .cnt_enable (cnt_enable),
        .cnt_modo   (cnt_modo),
        .cnt_D      (cnt_D),
        .cnt_rco    (cnt_rco),
        .busy       (busy),
        .done       (done),
        .wraps      (wraps)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream mode counter: registered rco, held while disabled.
    always @(posedge clk) begin
        logic [3:0] nq;
        logic       nr;
        cyc++;
        if (!reset) begin
            ctr_q   <= 4'h0;
            cnt_rco <= 1'b0;
        end else if (cnt_enable) begin
            en_cycles++;
            case (cnt_modo)
                2'b00:   begin nq = ctr_q + 4'd1; nr = (ctr_q == 4'hF); end
                2'b01:   begin nq = ctr_q - 4'd1; nr = (ctr_q == 4'h0); end
                2'b10:   begin nq = ctr_q - 4'd3; nr = (ctr_q < 4'd3);  end
                default: begin nq = cnt_D;        nr = 1'b1;            end
            endcase
            ctr_q   <= nq;
            cnt_rco <= nr;
            q_hist.push_back(nq);
        end
    end

    // Expected wraps from the command alone, replayed on a predicted counter value.
    function automatic logic [7:0] predict(input logic [1:0] m, input logic [3:0] d,
                                           input logic [7:0] len);
        logic [7:0] w = 8'd0;
        int n = (len == 8'd0) ? 1 : int'(len);
        for (int i = 0; i < n; i++) begin
            case (m)
                2'b00:   begin if (q_pred == 4'hF) w++; q_pred = q_pred + 4'd1; end
                2'b01:   begin if (q_pred == 4'h0) w++; q_pred = q_pred - 4'd1; end
                2'b10:   begin if (q_pred < 4'd3)  w++; q_pred = q_pred - 4'd3; end
                default: begin w++; q_pred = d; end
            endcase
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            n_done++;
            check("done_has_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("wraps", 32'(wraps), 32'(sb.pop_front()));
        end
    end

    // Leaves cmd_valid high so callers can stream commands back-to-back.
    task automatic push(input logic [1:0] m, input logic [3:0] d, input logic [7:0] len,
                        output int acc);
        int b = 0;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_data  = d;
        cmd_len   = len;
        while (cmd_ready !== 1'b1 && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("push_bound", 32'(b < 200), 32'd1);
        sb.push_back(predict(m, d, len));
        @(negedge clk);
        acc = cyc;
    endtask

    task automatic wait_idle();
        int b = 0;
        while (busy !== 1'b0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("idle_bound", 32'(b < 500), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int acc[6];
        int t0;
        logic [6:0] en_pat;
        logic [6:0] done_pat;
        en_pat   = 7'b0001110;
        done_pat = 7'b0100000;

        // 1: reset state
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("rst_enable", 32'(cnt_enable), 32'd0);
        check("rst_ready",  32'(cmd_ready),  32'd1);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_wraps",  32'(wraps),      32'd0);
        @(negedge clk);

        // 2: single +1 command, cycle-exact enable/done timing
        push(2'b00, 4'h0, 8'd3, t0);
        cmd_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("t2_enable_k%0d", k), 32'(cnt_enable), 32'(en_pat[k]));
            check($sformatf("t2_done_k%0d", k),   32'(done),       32'(done_pat[k]));
            if (k == 1) check("t2_modo", 32'(cnt_modo), 32'd0);
            @(negedge clk);
        end
        check("t2_busy_after", 32'(busy), 32'd0);

        // 3: load then count through a wrap
        push(2'b11, 4'hE, 8'd1, t0);
        cmd_valid = 1'b0;
        wait_idle();
        check("t3_wraps_load", 32'(wraps), 32'd1);
        check("t3_D_hold",     32'(cnt_D), 32'hE);
        check("t3_modo_hold",  32'(cnt_modo), 32'd3);
        q_hist.delete();
        push(2'b00, 4'h0, 8'd3, t0);
        cmd_valid = 1'b0;
        wait_idle();
        check("t3_qlen", 32'(q_hist.size()), 32'd3);
        if (q_hist.size() == 3) begin
            check("t3_q0", 32'(q_hist[0]), 32'hF);
            check("t3_q1", 32'(q_hist[1]), 32'h0);
            check("t3_q2", 32'(q_hist[2]), 32'h1);
        end
        check("t3_wraps_inc", 32'(wraps), 32'd1);

        // 4: back-pressure with six long commands
        t0 = n_done;
        for (int i = 0; i < 5; i++) push(2'b00, 4'h0, 8'd20, acc[i]);
        check("t4_five_back_to_back", 32'(acc[4] - acc[0]), 32'd4);
        check("t4_ready_full", 32'(cmd_ready), 32'd0);
        push(2'b00, 4'h0, 8'd20, acc[5]);
        cmd_valid = 1'b0;
        check("t4_sixth_accept", 32'(acc[5] - acc[0]), 32'd24);
        wait_idle();
        check("t4_done_count", 32'(n_done - t0), 32'd6);

        // 5: zero length on a decrement from 0
        push(2'b11, 4'h0, 8'd1, t0);
        cmd_valid = 1'b0;
        wait_idle();
        en_cycles = 0;
        push(2'b01, 4'h5, 8'd0, t0);
        cmd_valid = 1'b0;
        wait_idle();
        check("t5_one_enable", 32'(en_cycles), 32'd1);
        check("t5_wraps", 32'(wraps), 32'd1);

        // 6: reset aborts a running command and flushes the queue
        for (int i = 0; i < 3; i++) push(2'b00, 4'h0, 8'd20, acc[i]);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        t0 = n_done;
        reset = 1'b0;
        sb.delete();
        q_pred = 4'h0;
        @(negedge clk);
        check("t6_enable", 32'(cnt_enable), 32'd0);
        check("t6_busy",   32'(busy),       32'd0);
        check("t6_ready",  32'(cmd_ready),  32'd1);
        check("t6_done",   32'(done),       32'd0);
        check("t6_wraps",  32'(wraps),      32'd0);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_no_done", 32'(n_done - t0), 32'd0);
        check("t6_busy_after", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
